// File: rtl/dmem_ctrl.sv
// Data-side memory controller: word reads and byte-enabled writes to an internal
// synchronous array, with a fixed number of wait states and out-of-range reporting.
module dmem_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int DEPTH           = 1024,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic                       data_we,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       data_err,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                     state, state_n;
    logic [3:0]                 cnt, cnt_n;
    logic [DATA_WIDTH-1:0]      lat_addr, lat_wdata;
    logic                       lat_we;
    logic [BYTE_DATA_WIDTH-1:0] lat_be;

    logic                       accept, enter_resp;
    logic [DATA_WIDTH-1:0]      cur_addr, cur_wdata, cur_word;
    logic                       cur_we, cur_in;
    logic [BYTE_DATA_WIDTH-1:0] cur_be;
    logic [AW-1:0]              cur_idx;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    // With zero wait states the response is produced on the acceptance edge,
    // so the live inputs stand in for the not-yet-latched copy.
    assign accept    = (state == IDLE) && data_req;
    assign cur_addr  = accept ? data_addr   : lat_addr;
    assign cur_wdata = accept ? wdata       : lat_wdata;
    assign cur_we    = accept ? data_we     : lat_we;
    assign cur_be    = accept ? byte_enable : lat_be;
    assign cur_word  = cur_addr >> 2;
    assign cur_in    = cur_word < DATA_WIDTH'(DEPTH);
    assign cur_idx   = cur_word[AW-1:0];
    assign busy      = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    cnt_n = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            data_valid <= 1'b0;
            rdata      <= '0;
            data_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_addr  <= data_addr;
                lat_wdata <= wdata;
                lat_we    <= data_we;
                lat_be    <= byte_enable;
            end
            data_valid <= enter_resp;
            data_err   <= enter_resp && !cur_in;
            rdata      <= (enter_resp && !cur_we && cur_in) ? mem[cur_idx] : '0;
        end
    end

    // Writes commit on the edge that enters RESP, so a read accepted afterwards sees them.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_we && cur_in) begin
            for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_dmem_ctrl;

    logic        clk, rst, data_req, data_we;
    logic [31:0] data_addr, wdata;
    logic [3:0]  byte_enable;
    logic        v0, e0, b0, v1, e1, b1;
    logic [31:0] rd0, rd1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [1024];
    bit          ref_ok  [1024];

    dmem_ctrl #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .wdata(wdata), .byte_enable(byte_enable), .data_valid(v0), .rdata(rd0),
        .data_err(e0), .busy(b0)
    );

    dmem_ctrl #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .wdata(wdata), .byte_enable(byte_enable), .data_valid(v1), .rdata(rd1),
        .data_err(e1), .busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the WAIT_CYCLES=2 instance; also predicts the response from the model.
    task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic err,
                          output int lat, output logic after_v, output logic [31:0] exp_rd,
                          output logic exp_err, output bit known);
        bit in_r;
        int idx;
        logic [31:0] lane;
        in_r    = (a / 4) < 32'd1024;
        idx     = in_r ? int'(a / 4) : 0;
        exp_err = !in_r;
        exp_rd  = 32'h0;
        known   = 1'b1;
        if (in_r && !we) begin
            if (ref_ok[idx]) exp_rd = ref_mem[idx];
            else known = 1'b0;
        end
        if (in_r && we) begin
            for (int i = 0; i < 4; i++) begin
                lane = 32'hFF << (8 * i);
                if (be[i]) ref_mem[idx] = (ref_mem[idx] & ~lane) | (wd & lane);
            end
            ref_ok[idx] = ref_ok[idx] || (be == 4'hF);
        end
        @(negedge clk);
        data_req = 1'b1; data_addr = a; data_we = we; wdata = wd; byte_enable = be;
        @(posedge clk); #1;
        data_req = 1'b0; data_addr = $urandom; data_we = 1'($urandom);
        wdata = $urandom; byte_enable = 4'($urandom);
        lat = -1; rd = 'x; err = 'x;
        for (int k = 0; k < 20; k++) begin
            if (v0 === 1'b1) begin
                lat = k; rd = rd0; err = e0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        after_v = v0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_req = 1'b0; data_we = 1'b0;
        data_addr = '0; wdata = '0; byte_enable = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({v0, b0, e0, rd0, v1, b1, e1, rd1} !== 70'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs cycle %0d: got v=%b busy=%b err=%b rdata=%h / v=%b busy=%b err=%b rdata=%h want all zero",
                         c, v0, b0, e0, rd0, v1, b1, e1, rd1);
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] rd, xr; logic err, xe, av; int lat; bit kn;
        access(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("[TB] FAIL write_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({err, rd} !== 33'h0) begin n_fail++; $display("[TB] FAIL write_resp: got err=%b rdata=%h want 0/0", err, rd); end
        n_cmp++;
        if (av !== 1'b0) begin n_fail++; $display("[TB] FAIL valid_one_cycle: got %b want 0", av); end
        access(32'h10, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL read_back: got %h err=%b want deadbeef err=0", rd, err);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd, xr; logic err, xe, av; int lat; bit kn;
        access(32'h40, 1'b1, 32'hAAAAAAAA, 4'hF, rd, err, lat, av, xr, xe, kn);
        access(32'h40, 1'b1, 32'h11223344, 4'h5, rd, err, lat, av, xr, xe, kn);
        access(32'h40, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'hAA22AA44) begin n_fail++; $display("[TB] FAIL partial_write: got %h want aa22aa44", rd); end
        access(32'h43, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'hAA22AA44) begin n_fail++; $display("[TB] FAIL offset_ignored: got %h want aa22aa44", rd); end
        access(32'h40, 1'b1, 32'hFFFFFFFF, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (lat !== 2 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL be0_resp: got lat=%0d err=%b want 2/0", lat, err); end
        access(32'h41, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'hAA22AA44) begin n_fail++; $display("[TB] FAIL be0_nochange: got %h want aa22aa44", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, xr; logic err, xe, av; int lat; bit kn;
        access(32'h0, 1'b1, 32'h01234567, 4'hF, rd, err, lat, av, xr, xe, kn);
        access(32'h1000, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("[TB] FAIL oor_read: got lat=%0d err=%b rdata=%h want 2/1/0", lat, err, rd);
        end
        access(32'h1000, 1'b1, 32'hFEEDFACE, 4'hF, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_write: got err=%b rdata=%h want 1/0", err, rd); end
        access(32'h0, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'h01234567) begin n_fail++; $display("[TB] FAIL oor_no_alias: got %h want 01234567", rd); end
        access(32'h40000000, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_high_addr: got err=%b rdata=%h want 1/0", err, rd); end
        access(32'hFFC, 1'b1, 32'hCAFEF00D, 4'hF, rd, err, lat, av, xr, xe, kn);
        access(32'hFFF, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL last_word: got err=%b rdata=%h want 0/cafef00d", err, rd); end
    endtask

    task automatic test_read_after_write();
        logic [31:0] wd, last; int nv;
        wd = $urandom; nv = 0; last = 'x;
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h30; data_we = 1'b1; wdata = wd; byte_enable = 4'hF;
        @(posedge clk); #1;
        data_we = 1'b0; wdata = ~wd;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) data_req = 1'b0;
            if (v0 === 1'b1) begin nv++; last = rd0; end
            @(posedge clk); #1;
        end
        ref_mem[12] = wd; ref_ok[12] = 1'b1;
        n_cmp++;
        if (nv !== 2 || last !== wd) begin
            n_fail++; $display("[TB] FAIL read_after_write: got %0d pulses rdata=%h want 2 pulses rdata=%h", nv, last, wd);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] gv0, gb0, gv1, gb1, xv0, xb0, xv1, xb1;
        int p;
        xv0 = '0; xb0 = '0; xv1 = '0; xb1 = '0;
        // Requests are accepted at cycle offsets n*(W+2) while data_req stays high (through offset 4).
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n < 3; n++) begin
                p = n * 4;
                if (p <= 4 && k == p + 2) xv0[k] = 1'b1;
                if (p <= 4 && k >= p && k <= p + 2) xb0[k] = 1'b1;
                p = n * 2;
                if (p <= 4 && k == p) xv1[k] = 1'b1;
                if (p <= 4 && k == p) xb1[k] = 1'b1;
            end
        end
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8; data_we = 1'b0; byte_enable = 4'h0;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) data_req = 1'b0;
            gv0[k] = v0; gb0[k] = b0; gv1[k] = v1; gb1[k] = b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (gv1 !== xv1) begin n_fail++; $display("[TB] FAIL b2b_valid_w0: got %b want %b", gv1, xv1); end
        n_cmp++;
        if (gb1 !== xb1) begin n_fail++; $display("[TB] FAIL b2b_busy_w0: got %b want %b", gb1, xb1); end
        n_cmp++;
        if (gv0 !== xv0) begin n_fail++; $display("[TB] FAIL b2b_valid_w2: got %b want %b", gv0, xv0); end
        n_cmp++;
        if (gb0 !== xb0) begin n_fail++; $display("[TB] FAIL b2b_busy_w2: got %b want %b", gb0, xb0); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd, xr; logic err, xe, av; int lat, nv; bit kn;
        access(32'h20, 1'b1, 32'h5A5A5A5A, 4'hF, rd, err, lat, av, xr, xe, kn);
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h20; data_we = 1'b1; wdata = 32'h0BADF00D; byte_enable = 4'hF;
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (v0 !== 1'b0 || b0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_state: got v=%b busy=%b want 0/0", v0, b0); end
        @(negedge clk); rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (v0 === 1'b1) nv++;
        end
        n_cmp++;
        if (nv !== 0) begin n_fail++; $display("[TB] FAIL reset_drop_valid: got %0d pulses want 0", nv); end
        access(32'h20, 1'b0, 32'h0, 4'h0, rd, err, lat, av, xr, xe, kn);
        n_cmp++;
        if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("[TB] FAIL reset_no_commit: got %h want 5a5a5a5a", rd); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, xr; logic we, err, xe, av; logic [3:0] be; int lat; bit kn;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                if (a < 32'h1000) a = a + 32'h1000;
            end else begin
                a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            end
            we = 1'($urandom); wd = $urandom; be = 4'($urandom);
            access(a, we, wd, be, rd, err, lat, av, xr, xe, kn);
            n_cmp++;
            if (lat !== 2 || av !== 1'b0) begin
                n_fail++; $display("[TB] FAIL rand_timing #%0d: got lat=%0d after=%b want 2/0", t, lat, av);
            end
            n_cmp++;
            if (err !== xe) begin n_fail++; $display("[TB] FAIL rand_err #%0d addr=%h: got %b want %b", t, a, err, xe); end
            if (kn) begin
                n_cmp++;
                if (rd !== xr) begin n_fail++; $display("[TB] FAIL rand_rdata #%0d addr=%h we=%b: got %h want %h", t, a, we, rd, xr); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_ok[i] = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_out_of_range();
        test_read_after_write();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
